// File: rtl/alarm_pkg.sv
// Shared types and widths for the car alarm sequencer.
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    localparam int SEC_W   = 8;
    localparam int COUNT_W = 4;

    function automatic int count_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/alarm_sequencer_second_ticker.sv
// One-second prescaler with synchronous clear; emits a tick at terminal count
// and the blink phase (high in the first half of each second).
module second_ticker
    import alarm_pkg::*;
#(
    parameter int CLOCK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic sec_tick,
    output logic blink_phase
);

    localparam int CW = count_width(CLOCK_HZ);
    localparam logic [CW-1:0] LAST = CW'(CLOCK_HZ - 1);
    localparam logic [CW-1:0] HALF = CW'(CLOCK_HZ / 2);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    always_comb begin
        if (clear || count == LAST) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(1);
        end
    end

    assign sec_tick = (count == LAST);
    // Phase of the value about to be loaded, so a registered LED lines up with the count.
    assign blink_phase = (count_next < HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Arm/disarm sequencer of the car security system: exit delay, armed watch,
// entry delay and timed alarm, with siren enable and status outputs.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int CLOCK_HZ      = 50_000_000,
    parameter int EXIT_DELAY_S  = 10,
    parameter int ENTRY_DELAY_S = 8,
    parameter int ALARM_TIME_S  = 30,
    parameter int MAX_ALARMS    = 3
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               armReq,
    input  logic               disarmReq,
    input  logic               doorOpen,
    input  logic               shock,
    output logic               siren,
    output logic               armedLed,
    output state_t             state,
    output logic [COUNT_W-1:0] alarmCount
);

    localparam logic [SEC_W-1:0]   EXIT_SECS  = SEC_W'(EXIT_DELAY_S);
    localparam logic [SEC_W-1:0]   ENTRY_SECS = SEC_W'(ENTRY_DELAY_S);
    localparam logic [SEC_W-1:0]   ALARM_SECS = SEC_W'(ALARM_TIME_S);
    localparam logic [COUNT_W-1:0] MAX_CNT    = COUNT_W'(MAX_ALARMS);

    logic             door_meta, door_sync;
    logic             shock_meta, shock_sync;
    logic [SEC_W-1:0] secs;
    logic             sec_tick, blink_phase;
    logic             expire, lockout, timer_clear;
    state_t           nxt;

    function automatic logic [SEC_W-1:0] delay_of(input state_t s);
        case (s)
            EXIT:    return EXIT_SECS;
            ENTRY:   return ENTRY_SECS;
            ALARM:   return ALARM_SECS;
            default: return '0;
        endcase
    endfunction

    second_ticker #(.CLOCK_HZ(CLOCK_HZ)) u_ticker (
        .clk        (clock),
        .rst_n      (resetN),
        .clear      (timer_clear),
        .sec_tick   (sec_tick),
        .blink_phase(blink_phase)
    );

    // Two-flop synchronisers for the raw asynchronous sensors.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            door_meta  <= 1'b0;
            door_sync  <= 1'b0;
            shock_meta <= 1'b0;
            shock_sync <= 1'b0;
        end else begin
            door_meta  <= doorOpen;
            door_sync  <= door_meta;
            shock_meta <= shock;
            shock_sync <= shock_meta;
        end
    end

    assign expire      = sec_tick && (secs == SEC_W'(1));
    assign lockout     = (alarmCount == MAX_CNT);
    assign timer_clear = (nxt != state);

    always_comb begin
        // NOTE: default assignment first so every path drives nxt and no latch is inferred.
        nxt = state;
        if (disarmReq) begin
            nxt = DISARMED;
        end else begin
            case (state)
                DISARMED: if (armReq) nxt = EXIT;
                EXIT:     if (expire) nxt = ARMED;
                ARMED: begin
                    if (!lockout) begin
                        if (shock_sync)     nxt = ALARM;
                        else if (door_sync) nxt = ENTRY;
                    end
                end
                ENTRY:    if (shock_sync || expire) nxt = ALARM;
                ALARM:    if (expire) nxt = ARMED;
                default:  nxt = DISARMED;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= DISARMED;
            siren      <= 1'b0;
            armedLed   <= 1'b0;
            alarmCount <= '0;
            secs       <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            state    <= nxt;
            siren    <= (nxt == ALARM);
            armedLed <= (nxt == EXIT) ? blink_phase : (nxt inside {ARMED, ENTRY, ALARM});
            if (disarmReq) begin
                alarmCount <= '0;
            end else if (nxt == ALARM && state != ALARM && !lockout) begin
                alarmCount <= alarmCount + COUNT_W'(1);
            end
            // Seconds reload on every state entry; triggers inside ALARM never reach here.
            if (timer_clear) begin
                secs <= delay_of(nxt);
            end else if (sec_tick && secs != '0) begin
                secs <= secs - SEC_W'(1);
            end
        end
    end

endmodule
